// File: rtl/alu_pkg.sv
// Shared mode codes and FSM state encoding for the accumulator ALU.
package alu_pkg;

  localparam logic [2:0] MODE_INC   = 3'd0;
  localparam logic [2:0] MODE_ADD   = 3'd1;
  localparam logic [2:0] MODE_SUB   = 3'd2;
  localparam logic [2:0] MODE_LOGIC = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_SHL   = 3'd5;
  localparam logic [2:0] MODE_SHR   = 3'd6;
  localparam logic [2:0] MODE_MUL   = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, W steps.
// o_product presents the value the current step produces, so it is final while o_last is high.
module shift_add_mult #(
  parameter int unsigned W = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_load,
  input  logic [W-1:0]   i_multiplicand,
  input  logic [W-1:0]   i_multiplier,
  output logic [2*W-1:0] o_product,
  output logic           o_last
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_prod;
  logic [CW-1:0]  r_cnt;
  logic           r_run;
  logic [2*W-1:0] w_next;

  assign w_next    = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign o_product = w_next;
  assign o_last    = r_run && (r_cnt == CW'(W - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= {{W{1'b0}}, i_multiplicand};
      r_mplier <= i_multiplier;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_prod   <= w_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_accum.sv
// Accumulator ALU: operand A against accumulator B, single-cycle ops plus iterative multiply.
// Define ALU_ACCUM_SAT_EN to make inc/add saturate high and sub saturate at zero.
module alu_accum
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [2:0]     i_mode,
  input  logic [W-1:0]   i_a,
  input  logic           i_acc_clr,
  output logic [2*W-1:0] o_result,
  output logic [W-1:0]   o_acc,
  output logic           o_busy,
  output logic           o_done
);

`ifdef ALU_ACCUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [0:0]     r_state;
  logic [2*W-1:0] r_result;
  logic [W-1:0]   r_acc;
  logic           r_done;

  logic [W-1:0]   w_b;
  logic [W:0]     w_inc;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [2*W-1:0] w_alu;
  logic           w_accept;
  logic           w_load;
  logic [2*W-1:0] w_product;
  logic           w_last;

  // A clear accepted alongside start makes the operation see B = 0.
  assign w_b   = i_acc_clr ? '0 : r_acc;
  assign w_inc = {1'b0, i_a} + (W + 1)'(1);
  assign w_add = {1'b0, i_a} + {1'b0, w_b};
  assign w_sub = {1'b0, i_a} - {1'b0, w_b};

  always_comb begin
    w_alu = '0;
    case (i_mode)
      MODE_INC: begin
        if (SAT_EN && w_inc[W]) w_alu = {{W{1'b0}}, {W{1'b1}}};
        else                    w_alu = {{(W-1){1'b0}}, w_inc};
      end
      MODE_ADD: begin
        if (SAT_EN && w_add[W]) w_alu = {{W{1'b0}}, {W{1'b1}}};
        else                    w_alu = {{(W-1){1'b0}}, w_add};
      end
      MODE_SUB: begin
        if (SAT_EN && w_sub[W]) w_alu = '0;
        else                    w_alu = {{(W-1){1'b0}}, w_sub};
      end
      MODE_LOGIC: w_alu = {i_a | w_b, i_a ^ w_b};
      MODE_ROR:   w_alu = {{(2*W-1){1'b0}}, |{i_a, w_b}};
      MODE_SHL:   w_alu = {{W{1'b0}}, w_b} << i_a;
      MODE_SHR:   w_alu = {{W{1'b0}}, w_b >> i_a};
      default:    w_alu = '0;
    endcase
  end

  assign w_accept = i_start && (r_state == ST_IDLE);
  assign w_load   = w_accept && (i_mode == MODE_MUL);

  shift_add_mult #(
    .W(W)
  ) u_mult (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_load         (w_load),
    .i_multiplicand (i_a),
    .i_multiplier   (w_b),
    .o_product      (w_product),
    .o_last         (w_last)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_acc_clr) r_acc <= '0;
      // Completion write-back is placed after the clear so it takes priority.
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_MUL;
          end else if (w_accept) begin
            r_result <= w_alu;
            r_acc    <= w_alu[W-1:0];
            r_done   <= 1'b1;
          end
        end
        ST_MUL: begin
          if (w_last) begin
            r_result <= w_product;
            r_acc    <= w_product[W-1:0];
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_acc    = r_acc;
  assign o_busy   = (r_state == ST_MUL);
  assign o_done   = r_done;

endmodule

// File: doc/alu_accum.md
Name: alu_accum

Overview:
Parametrised accumulator ALU. An operand A is combined with an internal accumulator register B under an 8-way mode code. B is loaded from the low half of each completed result.
All operations except multiply complete in one cycle. Multiply is an iterative shift-add taking W cycles, governed by a start/busy/done handshake.
The block is the arithmetic core behind the lab board's switch/HEX front end. It generalises the fixed 4-bit, single-cycle ALU to any width.

Parameters:
W, 4, operand and accumulator width in bits (W >= 2); result width is 2*W

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request an operation; sampled only when busy=0
mode  input  3  operation select, sampled with start
a  input  W  operand A, sampled with start
acc_clr  input  1  synchronous accumulator clear
result  output  2W  registered result of last completed operation
acc  output  W  accumulator B
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when result/acc update

Behaviour:
- Reset (async, any time, including mid-multiply): result=0, acc=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, MUL.
- IDLE, start=1, mode!=7: at the edge, result<=f(a,B), acc<=result[W-1:0], done=1 for the next cycle. Latency 1.
- IDLE, start=1, mode=7: snapshot a and B, clear the partial product, count<=0, go to MUL, busy=1.
- MUL: one iteration per cycle. On the W-th iteration edge:
  - result<=product, acc<=product[W-1:0]
  - done pulses, busy drops, FSM returns to IDLE
  - done therefore appears exactly W cycles after the start edge; busy is high for exactly W cycles.
- start while busy=1 is ignored; no queueing.
- Modes (B = accumulator value used as the operand; all results zero-extended to 2W):
  - 0: a+1; carry lands in bit W.
  - 1: a+B; carry in bit W.
  - 2: a-B; bit W = borrow; low W bits are two's-complement wrap.
  - 3: {a|B, a^B}; upper W bits are OR, lower W bits are XOR.
  - 4: reduction OR of {a,B} in bit 0; all other bits 0.
  - 5: zero-extended B shifted left by a; shift amount >= 2W gives 0.
  - 6: B shifted right by a; shift amount >= W gives 0.
  - 7: unsigned a*B, full 2W bits.
- acc_clr:
  - at the edge, acc<=0.
  - If start is also accepted that cycle, the operation uses B=0 and its write-back wins (acc = new result low half).
  - During MUL, acc_clr zeroes acc but does not abort; completion write-back still occurs using the snapshot.
- result holds between operations; done=0 except for the completion pulse.

Optional Feature:
Macro ALU_ACCUM_SAT_EN.
- Defined: modes 0 and 1 saturate. On carry, result = {W zeros, W ones}. Mode 2 saturates at 0 on borrow, with result=0. acc receives the saturated low half.
- Undefined: wrap-around with carry/borrow in bit W, as specified above.
- All other modes are unaffected either way.

Decomposition:
- Shared package alu_pkg holds:
  - mode codes as named constants: MODE_INC, MODE_ADD, MODE_SUB, MODE_LOGIC, MODE_ROR, MODE_SHL, MODE_SHR, MODE_MUL
  - FSM state encoding (ST_IDLE, ST_MUL)
- One natural sub-module, shift_add_mult, parametrised by W:
  - inputs: clock, reset, load, multiplicand, multiplier
  - outputs: product, last (asserted on the W-th iteration)
  - the top-level FSM and write-back stay in alu_accum.

Test Plan (W=4):
- Reset, then start mode=0, a=4'hF -> done next cycle, result=8'h10, acc=4'h0.
- acc preloaded to 9 (mode 1 with a=9 after clear), then start mode=1, a=9:
  - without SAT -> result=8'h12, acc=4'h2
  - with ALU_ACCUM_SAT_EN -> result=8'h0F, acc=4'hF
- acc=F, start mode=7, a=F -> busy high 4 cycles, done on the 4th cycle after start, result=8'hE1, acc=4'h1. A start pulse mid-multiply is ignored, and no extra done pulse follows.
- Shifts:
  - acc=5, mode=5, a=3 -> result=8'h28
  - acc=1, mode=5, a=9 -> result=8'h00
  - acc=8, mode=6, a=3 -> result=8'h01
- acc=7, start mode=1, a=3 with acc_clr=1 the same cycle -> result=8'h03, acc=4'h3.
- Assert reset two cycles into a multiply -> immediately busy=0, done=0, result=0, acc=0. A following start mode=4, a=0 -> result=8'h00.
